// File: rtl/prio_enc_pkg.sv
// Shared types and the find-first-set helper for priority encoders and arbiters.
package prio_enc_pkg;

   localparam int unsigned MaxWidth = 64;
   localparam int unsigned MaxIdxW  = 6;

   typedef enum logic {
      StIdle,
      StScan
   } state_e;

   // Returns {found, idx}; MSB-first unless lsb_first is set.
   function automatic logic [MaxIdxW:0] find_first(input logic [MaxWidth-1:0] vec,
                                                   input logic                lsb_first);
      logic               found;
      logic [MaxIdxW-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < MaxWidth; i++) begin
         if (vec[i]) begin
            if (!lsb_first || !found) begin
               idx = MaxIdxW'(i);
            end
            found = 1'b1;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first-set over WIDTH bits with a selectable search direction.
module prio_find_first
   import prio_enc_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   input  logic             lsb_first_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [MaxIdxW:0] unused_res;

   always_comb begin
      unused_res = find_first(MaxWidth'(vec_i), lsb_first_i);
      found_o    = unused_res[MaxIdxW];
      idx_o      = unused_res[IDX_W-1:0];
   end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: emits one set-bit index per beat, MSB first by default.
// Define PRIO_ENC_LSB_FIRST_EN to drain in ascending index order instead.
module priority_encoder_seq
   import prio_enc_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

`ifdef PRIO_ENC_LSB_FIRST_EN
   localparam logic LsbFirst = 1'b1;
`else
   localparam logic LsbFirst = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             out_none_q, out_none_d;

   logic             accept;
   logic             beat_done;
   logic [WIDTH-1:0] scan_src;
   logic [WIDTH-1:0] remaining;
   logic             ff_found;
   logic [IDX_W-1:0] ff_idx;

   assign out_valid = (state_q == StScan);
   assign busy      = (state_q == StScan);
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_none  = out_none_q;

   assign beat_done = out_valid & out_ready;
   assign in_ready  = (state_q == StIdle) | (beat_done & out_last_q);
   assign accept    = in_valid & in_ready;

   // A single finder serves both the fresh vector and the pending drain.
   assign scan_src  = accept ? in_vec : pend_q;
   assign remaining = scan_src & ~(WIDTH'(1) << ff_idx);

   prio_find_first #(
      .WIDTH (WIDTH)
   ) u_find_first (
      .vec_i       (scan_src),
      .lsb_first_i (LsbFirst),
      .found_o     (ff_found),
      .idx_o       (ff_idx)
   );

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
      out_none_d = out_none_q;

      if (accept) begin
         state_d = StScan;
         if (ff_found) begin
            out_idx_d  = ff_idx;
            pend_d     = remaining;
            out_last_d = (remaining == '0);
            out_none_d = 1'b0;
         end else begin
            out_idx_d  = '0;
            pend_d     = '0;
            out_last_d = 1'b1;
            out_none_d = 1'b1;
         end
      end else if (beat_done && !out_last_q) begin
         out_idx_d  = ff_idx;
         pend_d     = remaining;
         out_last_d = (remaining == '0);
      end else if (beat_done) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         pend_q     <= '0;
         out_idx_q  <= '0;
         out_last_q <= 1'b0;
         out_none_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         out_idx_q  <= out_idx_d;
         out_last_q <= out_last_d;
         out_none_q <= out_none_d;
      end
   end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench for priority_encoder_seq (WIDTH=8) against a queue-based beat model.
module tb_priority_encoder_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDX_W = $clog2(WIDTH);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_none;
   logic             busy;

   int checks;
   int failures;

   priority_encoder_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected drain order: list of set indices in priority order, or a lone "none" beat.
   task automatic model_beats(input logic [WIDTH-1:0] v, output int idx_q[$]);
      idx_q = {};
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (v[i]) begin
`ifdef PRIO_ENC_LSB_FIRST_EN
            idx_q.push_back(i);
`else
            idx_q.push_front(i);
`endif
         end
      end
   endtask

   task automatic check_beat(input string tag, input int exp_idx, input bit exp_last,
                             input bit exp_none, input bit exp_in_ready);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".idx"}, 32'(out_idx), 32'(exp_idx));
      check({tag, ".last"}, 32'(out_last), 32'(exp_last));
      check({tag, ".none"}, 32'(out_none), 32'(exp_none));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_in_ready));
   endtask

   // Present one vector from idle and drain it, stalling on beat stall_beat for stall_cycles.
   task automatic send_and_drain(input string tag, input logic [WIDTH-1:0] v,
                                 input int stall_beat, input int stall_cycles);
      int  idx_q[$];
      int  n;
      bit  none;
      @(negedge clk);
      in_valid  = 1'b1;
      in_vec    = v;
      out_ready = 1'b1;
      #1;
      check({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_vec   = WIDTH'($urandom);
      model_beats(v, idx_q);
      none = (idx_q.size() == 0);
      if (none) idx_q.push_back(0);
      n = idx_q.size();
      for (int b = 0; b < n; b++) begin
         if (b == stall_beat) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               #1;
               check_beat({tag, ".stall"}, idx_q[b], b == n - 1, none, 1'b0);
               @(negedge clk);
               in_vec = WIDTH'($urandom);
            end
            out_ready = 1'b1;
         end
         #1;
         check_beat(tag, idx_q[b], b == n - 1, none, b == n - 1);
         @(negedge clk);
      end
      #1;
      check({tag, ".drained_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".drained_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b0;
      #1;
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.out_idx", 32'(out_idx), 32'd0);
      check("reset.out_last", 32'(out_last), 32'd0);
      check("reset.out_none", 32'(out_none), 32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send_and_drain("two_ends", 8'b1000_0001, -1, 0);
      send_and_drain("zero", 8'b0000_0000, -1, 0);
      send_and_drain("stall", 8'b0110_1000, 1, 3);

      // Back-to-back vectors with in_valid held across the final handshake.
      @(negedge clk);
      in_valid  = 1'b1;
      in_vec    = 8'b0000_0100;
      out_ready = 1'b1;
      @(negedge clk);
      in_vec = 8'b0001_0000;
      #1;
      check_beat("b2b_first", 2, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_beat("b2b_second", 4, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check("b2b_no_extra", 32'(out_valid), 32'd0);

      // Reset in the middle of a drain.
      @(negedge clk);
      in_valid = 1'b1;
      in_vec   = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid.pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid.valid", 32'(out_valid), 32'd0);
      check("rst_mid.busy", 32'(busy), 32'd0);
      check("rst_mid.idx", 32'(out_idx), 32'd0);
      check("rst_mid.last", 32'(out_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_mid.release_valid", 32'(out_valid), 32'd0);
      send_and_drain("after_rst", 8'h01, -1, 0);

      for (int r = 0; r < 40; r++) begin
         logic [WIDTH-1:0] v;
         v = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         send_and_drain($sformatf("rand%0d", r), v, int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
